// File: rtl/matmul_sequencer.sv
// -----------------------------------------------------------------------------
// matmul_sequencer
//
// Time-multiplexed signed matrix multiply C = A x B built around one shared
// multiply-accumulate unit. An operation runs in three phases:
//   LOAD    : A (row-major) then B (row-major) arrive as a valid/ready stream.
//   COMPUTE : one MAC per cycle, loop order i (row of A) outer, j (column of
//             B) middle, k (inner dimension) inner. No idle cycle between
//             C elements: the accumulator restarts whenever k wraps to 0.
//   OUTPUT  : C is streamed row-major from (0,0) under consumer backpressure.
//
// Handshake rule (both streams): a transfer happens on a rising clk edge
// exactly when valid and ready are both high in the cycle before that edge.
// in_ready and out_valid depend only on the current state, never on the
// partner's valid/ready, so there is no combinational path between them.
// While out_valid is high and out_ready is low, out_data/out_row/out_col are
// held stable.
//
// Ports:
//   clk        in   single clock, everything on the rising edge
//   reset      in   synchronous, active-high; abandons any operation
//   start      in   begin an operation; only looked at in IDLE
//   in_valid   in   in_data carries an element
//   in_ready   out  high for the whole LOAD phase
//   in_data    in   signed W_IN element, A row-major then B row-major
//   out_valid  out  out_data/out_row/out_col carry a C element
//   out_ready  in   consumer takes the current C element
//   out_data   out  signed W_OUT C element (0 outside OUTPUT)
//   out_row    out  row index of out_data
//   out_col    out  column index of out_data
//   busy       out  high in any state other than IDLE
//   done       out  one-cycle pulse after the last C element is taken
//   state_dbg  out  current FSM state encoding, for checkers and debug
// -----------------------------------------------------------------------------
module matmul_sequencer #(
    parameter int W_IN   = 8,
    parameter int W_OUT  = 17,
    parameter int ROWS_A = 2,
    parameter int COLS_A = 2,
    parameter int COLS_B = 2
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         start,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic signed [W_IN-1:0]                       in_data,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic signed [W_OUT-1:0]                      out_data,
    output logic [((ROWS_A > 1) ? $clog2(ROWS_A) : 1)-1:0] out_row,
    output logic [((COLS_B > 1) ? $clog2(COLS_B) : 1)-1:0] out_col,
    output logic                                         busy,
    output logic                                         done,
    output logic [1:0]                                   state_dbg
);

    // -------------------------------------------------------------------------
    // Sizes and index widths. Every index is at least one bit wide so that
    // single-row or single-column shapes still elaborate.
    // -------------------------------------------------------------------------
    localparam int NA  = ROWS_A * COLS_A;   // elements of A
    localparam int NB  = COLS_A * COLS_B;   // elements of B
    localparam int NC  = ROWS_A * COLS_B;   // elements of C
    localparam int NL  = NA + NB;           // load beats per operation

    localparam int RW  = (ROWS_A > 1) ? $clog2(ROWS_A) : 1;
    localparam int CW  = (COLS_B > 1) ? $clog2(COLS_B) : 1;
    localparam int KW  = (COLS_A > 1) ? $clog2(COLS_A) : 1;
    localparam int LW  = (NL > 1) ? $clog2(NL) : 1;
    localparam int AW  = (NA > 1) ? $clog2(NA) : 1;
    localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int CIW = (NC > 1) ? $clog2(NC) : 1;

    localparam int PW  = 2 * W_IN;          // full signed product width

    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS_A - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS_B - 1);
    localparam logic [KW-1:0] K_LAST     = KW'(COLS_A - 1);
    localparam logic [LW-1:0] LD_LAST    = LW'(NL - 1);
    localparam logic [LW-1:0] LD_B_FIRST = LW'(NA);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // -------------------------------------------------------------------------
    // Storage and counters
    // -------------------------------------------------------------------------
    logic signed [W_IN-1:0]  a_mem [NA];
    logic signed [W_IN-1:0]  b_mem [NB];
    logic signed [W_OUT-1:0] c_mem [NC];

    logic [LW-1:0]           ld_cnt;     // load beat number
    logic [RW-1:0]           mac_i;      // row of A / row of C
    logic [CW-1:0]           mac_j;      // column of B / column of C
    logic [KW-1:0]           mac_k;      // inner dimension
    logic [RW-1:0]           out_r;      // row of the C element on offer
    logic [CW-1:0]           out_c;      // column of the C element on offer
    logic signed [W_OUT-1:0] acc;
    logic                    done_q;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic                    in_accept;
    logic                    ld_last;
    logic                    mac_last;
    logic                    out_last;

    logic [AW-1:0]           a_ld_idx;
    logic [BW-1:0]           b_ld_idx;
    logic [AW-1:0]           a_idx;
    logic [BW-1:0]           b_idx;
    logic [CIW-1:0]          c_wr_idx;
    logic [CIW-1:0]          c_rd_idx;

    logic signed [W_IN-1:0]  a_el;
    logic signed [W_IN-1:0]  b_el;
    logic signed [PW-1:0]    prod;
    logic signed [W_OUT-1:0] prod_ext;
    logic signed [W_OUT-1:0] acc_base;
    logic signed [W_OUT-1:0] acc_sum;

    assign in_accept = in_valid & in_ready;
    assign ld_last   = (ld_cnt == LD_LAST);
    assign mac_last  = (mac_i == ROW_LAST) && (mac_j == COL_LAST) && (mac_k == K_LAST);
    assign out_last  = (out_r == ROW_LAST) && (out_c == COL_LAST);

    // Load addressing: the first NA beats land in A, the rest in B.
    assign a_ld_idx  = AW'(ld_cnt);
    assign b_ld_idx  = BW'(ld_cnt - LD_B_FIRST);

    // Row-major flattening of A[i][k], B[k][j] and C[i][j].
    assign a_idx     = AW'(int'(mac_i) * COLS_A + int'(mac_k));
    assign b_idx     = BW'(int'(mac_k) * COLS_B + int'(mac_j));
    assign c_wr_idx  = CIW'(int'(mac_i) * COLS_B + int'(mac_j));
    assign c_rd_idx  = CIW'(int'(out_r) * COLS_B + int'(out_c));

    // Both operands are widened with their sign before the multiply so the
    // product is the exact signed 2*W_IN-bit result; the accumulator then
    // sign-extends it and wraps modulo 2^W_OUT.
    assign a_el      = a_mem[a_idx];
    assign b_el      = b_mem[b_idx];
    assign prod      = PW'(a_el) * PW'(b_el);
    assign prod_ext  = W_OUT'(prod);

    // k == 0 starts a fresh dot product, so the previous C element's sum is
    // dropped without spending a cycle on clearing.
    assign acc_base  = (mac_k == '0) ? '0 : acc;
    assign acc_sum   = acc_base + prod_ext;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and state-derived outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && ld_last) begin
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (mac_last) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready && out_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // A/B storage. Contents are meaningless until reloaded, so no reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if ((state_q == LOAD) && in_accept) begin
            if (ld_cnt < LD_B_FIRST) begin
                a_mem[a_ld_idx] <= in_data;
            end else begin
                b_mem[b_ld_idx] <= in_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Counters, accumulator, C store and done pulse
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_cnt <= '0;
            mac_i  <= '0;
            mac_j  <= '0;
            mac_k  <= '0;
            out_r  <= '0;
            out_c  <= '0;
            acc    <= '0;
            done_q <= 1'b0;
            for (int n = 0; n < NC; n++) begin
                c_mem[n] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Counters already wrap back to zero at the end of every
                    // phase; clearing them again on start keeps a new run
                    // independent of whatever came before.
                    if (start) begin
                        ld_cnt <= '0;
                        mac_i  <= '0;
                        mac_j  <= '0;
                        mac_k  <= '0;
                        out_r  <= '0;
                        out_c  <= '0;
                    end
                end
                LOAD: begin
                    if (in_accept) begin
                        ld_cnt <= ld_last ? '0 : ld_cnt + LW'(1);
                    end
                end
                COMPUTE: begin
                    acc <= acc_sum;
                    if (mac_k == K_LAST) begin
                        c_mem[c_wr_idx] <= acc_sum;
                        mac_k <= '0;
                        if (mac_j == COL_LAST) begin
                            mac_j <= '0;
                            mac_i <= (mac_i == ROW_LAST) ? '0 : mac_i + RW'(1);
                        end else begin
                            mac_j <= mac_j + CW'(1);
                        end
                    end else begin
                        mac_k <= mac_k + KW'(1);
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_r  <= '0;
                            out_c  <= '0;
                            done_q <= 1'b1;
                        end else if (out_c == COL_LAST) begin
                            out_c <= '0;
                            out_r <= out_r + RW'(1);
                        end else begin
                            out_c <= out_c + CW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output mapping
    // -------------------------------------------------------------------------
    assign out_data  = (state_q == OUTPUT) ? c_mem[c_rd_idx] : '0;
    assign out_row   = out_r;
    assign out_col   = out_c;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for matmul_sequencer with the default 2x2x2, 8-bit -> 17-bit shape.
// Expected C values come from a table of hand-worked products and from a
// plain-arithmetic matrix product for randomised matrices.
// -----------------------------------------------------------------------------
module tb_matmul_sequencer;

    typedef struct packed {
        logic [3:0][7:0]  a;   // A row-major: a[i*2+k]
        logic [3:0][7:0]  b;   // B row-major: b[k*2+j]
        logic [3:0][16:0] c;   // expected C row-major: c[i*2+j]
    } vec_t;

    // -------------------------------------------------------------------------
    // Clock / reset / DUT
    // -------------------------------------------------------------------------
    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [16:0] out_data;
    logic [0:0]         out_row;
    logic [0:0]         out_col;
    logic               busy;
    logic               done;
    logic [1:0]         state_dbg;

    always #5 clk = ~clk;

    matmul_sequencer #(
        .W_IN  (8),
        .W_OUT (17),
        .ROWS_A(2),
        .COLS_A(2),
        .COLS_B(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_row  (out_row),
        .out_col  (out_col),
        .busy     (busy),
        .done     (done),
        .state_dbg(state_dbg)
    );

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    int          checks   = 0;
    int          failures = 0;
    logic [18:0] exp_q[$];     // {c, row, col}
    vec_t        tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model and vector helpers
    // -------------------------------------------------------------------------
    function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3,
                                input int b0, input int b1, input int b2, input int b3,
                                input int c0, input int c1, input int c2, input int c3);
        vec_t v;
        v.a[0] = 8'(a0);  v.a[1] = 8'(a1);  v.a[2] = 8'(a2);  v.a[3] = 8'(a3);
        v.b[0] = 8'(b0);  v.b[1] = 8'(b1);  v.b[2] = 8'(b2);  v.b[3] = 8'(b3);
        v.c[0] = 17'(c0); v.c[1] = 17'(c1); v.c[2] = 17'(c2); v.c[3] = 17'(c3);
        return v;
    endfunction

    // C[i][j] = sum_k A[i][k]*B[k][j], reduced modulo 2^17.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   s;
        int   x;
        int   y;
        r = v;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = 0;
                for (int k = 0; k < 2; k++) begin
                    x = $signed(v.a[i*2+k]);
                    y = $signed(v.b[k*2+j]);
                    s += x * y;
                end
                r.c[i*2+j] = 17'(s);
            end
        end
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int n = 0; n < 4; n++) begin
            v.a[n] = 8'($urandom_range(0, 255));
            v.b[n] = 8'($urandom_range(0, 255));
            v.c[n] = '0;
        end
        return model(v);
    endfunction

    function automatic logic [7:0] elem(input vec_t v, input int beat);
        logic [7:0] e;
        if (beat < 4) e = v.a[beat];
        else          e = v.b[beat-4];
        return e;
    endfunction

    // -------------------------------------------------------------------------
    // Driver: one full operation.
    //   bubbles    : random in_valid gaps during load
    //   noise      : random start pulses while busy
    //   rand_ready : random out_ready backpressure
    //   stall_idx  : output element index held off for 5 cycles (-1 = none)
    //   prestarted : start was already given in the previous done cycle
    //   chain      : raise start in this run's done cycle
    // All driving and sampling happens on the falling edge.
    // -------------------------------------------------------------------------
    task automatic run_op(input vec_t v, input bit bubbles, input bit noise,
                          input bit rand_ready, input int stall_idx,
                          input bit prestarted, input bit chain);
        int          beats;
        int          cyc;
        int          taken;
        int          stall_left;
        bit          rdy;
        bit          bad_done;
        bit          holding;
        logic [18:0] held;
        logic [18:0] got;
        logic [18:0] e;

        bad_done   = 1'b0;
        holding    = 1'b0;
        held       = '0;
        stall_left = (stall_idx >= 0) ? 5 : 0;
        for (int n = 0; n < 4; n++) begin
            exp_q.push_back({v.c[n], 1'(n / 2), 1'(n % 2)});
        end

        if (prestarted) begin
            chk("done_one_cycle", {31'd0, done}, 32'd0);
        end else begin
            chk("idle_busy", {31'd0, busy}, 32'd0);
            start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        chk("load_ready", {31'd0, in_ready}, 32'd1);
        chk("load_busy", {31'd0, busy}, 32'd1);

        // load
        beats = 0;
        cyc   = 0;
        while (beats < 8 && cyc < 200) begin
            in_valid = bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = elem(v, beats);
            if (noise) start = 1'($urandom_range(0, 1));
            rdy = in_ready;
            if (done || out_valid) bad_done = 1'b1;
            @(negedge clk);
            if (in_valid && rdy) beats++;
            cyc++;
        end
        chk("load_beats", beats, 8);
        in_valid = 1'b0;

        // compute
        chk("compute_in_ready", {31'd0, in_ready}, 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            if (done || in_ready) bad_done = 1'b1;
            if (noise) start = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
        end
        chk("compute_cycles", cyc, 8);

        // output
        taken = 0;
        cyc   = 0;
        while (taken < 4 && cyc < 100) begin
            if (done) bad_done = 1'b1;
            got = {out_data, out_row, out_col};
            chk("out_valid", {31'd0, out_valid}, 32'd1);
            if (holding) chk("hold_stable", got, held);
            if (taken == stall_idx && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (noise) start = 1'($urandom_range(0, 1));
            if (out_ready) begin
                e = exp_q.pop_front();
                chk("c_elem", got, e);
                taken++;
                holding = 1'b0;
            end else begin
                holding = 1'b1;
                held    = got;
            end
            @(negedge clk);
            cyc++;
        end
        chk("out_count", taken, 4);
        exp_q.delete();
        out_ready = 1'b0;

        // done cycle
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_idle", {31'd0, busy}, 32'd0);
        chk("done_no_valid", {31'd0, out_valid}, 32'd0);
        chk("no_stray_done", {31'd0, bad_done}, 32'd0);
        if (chain) begin
            start = 1'b1;
            @(negedge clk);
        end else begin
            start = 1'b0;
            @(negedge clk);
            chk("done_one_cycle", {31'd0, done}, 32'd0);
        end
    endtask

    // Load everything, reset a few cycles into COMPUTE, confirm nothing emerges.
    task automatic reset_mid_compute(input vec_t v);
        bit quiet_bad;
        quiet_bad = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        for (int n = 0; n < 8; n++) begin
            in_data = elem(v, n);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_busy", {31'd0, busy}, 32'd0);
        chk("mid_reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_reset_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        for (int n = 0; n < 15; n++) begin
            if (done || out_valid || busy) quiet_bad = 1'b1;
            @(negedge clk);
        end
        chk("post_reset_quiet", {31'd0, quiet_bad}, 32'd0);
    endtask

    // -------------------------------------------------------------------------
    // Watchdog
    // -------------------------------------------------------------------------
    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Test sequence
    // -------------------------------------------------------------------------
    initial begin
        bit prev_chain;
        bit this_chain;
        vec_t v;

        // hand-worked products
        tbl[0] = mk(1, 2, 3, 4,          5, 6, 7, 8,          19, 22, 43, 50);
        tbl[1] = mk(-128, -128, -128, -128, -128, -128, -128, -128,
                    32768, 32768, 32768, 32768);
        tbl[2] = mk(-1, 2, 3, -4,        5, -6, -7, 8,        -19, 22, 43, -50);
        tbl[3] = mk(1, 0, 0, 1,          -128, 127, 5, -7,    -128, 127, 5, -7);
        tbl[4] = mk(127, 127, 127, 127,  127, -128, 127, -128,
                    32258, -32512, 32258, -32512);

        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {15'd0, out_data}, 32'd0);
        chk("rst_out_row", {31'd0, out_row}, 32'd0);
        chk("rst_out_col", {31'd0, out_col}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd0);

        // table: ideal streams
        for (int t = 0; t < 5; t++) begin
            run_op(tbl[t], 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        end

        // load bubbles, then a 5-cycle stall on element (0,1)
        run_op(tbl[0], 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        run_op(tbl[0], 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);

        // reset during COMPUTE, then a clean run
        reset_mid_compute(tbl[2]);
        run_op(tbl[0], 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0);

        // start noise while busy, with random backpressure
        run_op(tbl[2], 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0);

        // back-to-back: start in the done cycle
        run_op(tbl[0], 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b1);
        run_op(tbl[2], 1'b0, 1'b0, 1'b0, -1, 1'b1, 1'b0);

        // randomised runs against the model
        prev_chain = 1'b0;
        for (int r = 0; r < 20; r++) begin
            v          = rand_vec();
            this_chain = (r < 19) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_op(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), (r % 3 == 0) ? int'($urandom_range(0, 3)) : -1,
                   prev_chain, this_chain);
            prev_chain = this_chain;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
